// File: rtl/keypad_scan_fifo.sv
// Keyboard matrix scanner: one-hot column strobes, synchronised row sampling,
// frame-based debounce with optional auto-repeat, and a key-code FIFO with a
// valid/ready pop interface.
module keypad_scan_fifo #(
   parameter int unsigned ROWS         = 4,
   parameter int unsigned COLS         = 4,
   parameter int unsigned SCAN_DIV     = 16,
   parameter int unsigned DEBOUNCE     = 3,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned REPEAT_DELAY = 8,
   parameter int unsigned REPEAT_RATE  = 2
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [ROWS-1:0]                 i_rows,
   output logic [COLS-1:0]                 o_cols,
   input  logic                            i_repeat_en,
   output logic                            o_key_valid,
   output logic [$clog2(ROWS*COLS)-1:0]    o_key_code,
   input  logic                            i_key_ready,
   output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
   output logic                            o_overflow,
   input  logic                            i_overflow_clr
);

   localparam int unsigned KW   = $clog2(ROWS*COLS);
   localparam int unsigned SW   = $clog2(SCAN_DIV);
   localparam int unsigned CLW  = $clog2(COLS);
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = $clog2(DEBOUNCE+1);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW   = $clog2(RMAX+1);

   localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV-1);
   localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS-1);
   localparam logic [CW-1:0]  DEB_L     = CW'(DEBOUNCE);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
   localparam logic [RW-1:0]  DLY_L     = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0]  RATE_L    = RW'(REPEAT_RATE);
   localparam logic [PW:0]    CNT_FULL  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StCand, StHeld, StRelease} state_t;

   // ---------------------------------------------------------------- scan
   logic [ROWS-1:0] r_rows_s1, r_rows_s2;
   logic [SW-1:0]   r_slot;
   logic [CLW-1:0]  r_col;
   logic            w_sample, w_frame_end;
   logic [1:0]      w_col_hits, r_acc_hits, w_tot_hits;
   logic [2:0]      w_sum;
   logic [KW-1:0]   w_col_code, r_acc_code, w_tot_code;
   logic            w_none, w_single, w_multi;

   assign w_sample    = (r_slot == SLOT_LAST);
   assign w_frame_end = w_sample && (r_col == COL_LAST);

   // Two-flop synchroniser on the asynchronous row lines
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rows_s1 <= '0;
         r_rows_s2 <= '0;
      end else begin
         r_rows_s1 <= i_rows;
         r_rows_s2 <= r_rows_s1;
      end
   end

   // Slot/column counters and per-frame hit accumulator
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_slot     <= '0;
         r_col      <= '0;
         r_acc_hits <= '0;
         r_acc_code <= '0;
      end else begin
         if (w_sample) begin
            r_slot <= '0;
            r_col  <= (r_col == COL_LAST) ? '0 : r_col + CLW'(1);
            if (w_frame_end) begin
               r_acc_hits <= '0;
               r_acc_code <= '0;
            end else begin
               r_acc_hits <= w_tot_hits;
               r_acc_code <= w_tot_code;
            end
         end else begin
            r_slot <= r_slot + SW'(1);
         end
      end
   end

   // One-hot column strobe from the column counter
   always_comb begin
      o_cols        = '0;
      o_cols[r_col] = 1'b1;
   end

   // Count hits in the current column (saturating at 2) and encode the hit key
   always_comb begin
      w_col_hits = 2'd0;
      w_col_code = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (r_rows_s2[r]) begin
            if (w_col_hits != 2'd2) w_col_hits = w_col_hits + 2'd1;
            w_col_code = KW'(r * COLS) + KW'(r_col);
         end
      end
   end

   // Merge the current column into the frame totals; only meaningful on a sample
   always_comb begin
      w_sum      = {1'b0, r_acc_hits} + {1'b0, w_col_hits};
      w_tot_hits = (w_sum > 3'd2) ? 2'd2 : w_sum[1:0];
      w_tot_code = (r_acc_hits == 2'd0) ? w_col_code : r_acc_code;
      w_none     = (w_tot_hits == 2'd0);
      w_single   = (w_tot_hits == 2'd1);
      w_multi    = (w_tot_hits == 2'd2);
   end

   // ---------------------------------------------------------------- debounce FSM
   state_t        r_state, w_state_d;
   logic [KW-1:0] r_cand, w_cand_d;
   logic [CW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
   logic [RW-1:0] r_rep, w_rep_d, w_rep_inc;
   logic          r_phase, w_phase_d;
   logic          w_push, w_match;

   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_rep_inc = r_rep + RW'(1);
   assign w_match   = w_single && (w_tot_code == r_cand);

   // Next-state decode, evaluated only at frame end; the push is combinational so
   // the FIFO captures it on the frame-end edge itself
   always_comb begin
      w_state_d = r_state;
      w_cand_d  = r_cand;
      w_cnt_d   = r_cnt;
      w_rep_d   = r_rep;
      w_phase_d = r_phase;
      w_push    = 1'b0;
      if (w_frame_end) begin
         case (r_state)
            StIdle: begin
               if (w_single) begin
                  w_cand_d = w_tot_code;
                  if (DEBOUNCE == 1) begin
                     w_push    = 1'b1;
                     w_state_d = StHeld;
                     w_rep_d   = '0;
                     w_phase_d = 1'b0;
                  end else begin
                     w_state_d = StCand;
                     w_cnt_d   = CNT_ONE;
                  end
               end
            end
            StCand: begin
               if (w_match) begin
                  w_cnt_d = w_cnt_inc;
                  if (w_cnt_inc == DEB_L) begin
                     w_push    = 1'b1;
                     w_state_d = StHeld;
                     w_rep_d   = '0;
                     w_phase_d = 1'b0;
                  end
               end else if (w_single) begin
                  w_cand_d = w_tot_code;
                  w_cnt_d  = CNT_ONE;
               end else begin
                  w_state_d = StIdle;
               end
            end
            StHeld: begin
               if (w_match) begin
                  if (i_repeat_en) begin
                     // First repeat waits REPEAT_DELAY frames, later ones REPEAT_RATE
                     if (w_rep_inc == (r_phase ? RATE_L : DLY_L)) begin
                        w_push    = 1'b1;
                        w_rep_d   = '0;
                        w_phase_d = 1'b1;
                     end else begin
                        w_rep_d = w_rep_inc;
                     end
                  end else begin
                     w_rep_d   = '0;
                     w_phase_d = 1'b0;
                  end
               end else if (!w_multi) begin
                  w_cnt_d   = CNT_ONE;
                  w_state_d = (DEBOUNCE == 1) ? StIdle : StRelease;
               end
            end
            StRelease: begin
               if (w_match) begin
                  w_state_d = StHeld;
                  w_rep_d   = '0;
                  w_phase_d = 1'b0;
               end else begin
                  w_cnt_d = w_cnt_inc;
                  if (w_cnt_inc == DEB_L) w_state_d = StIdle;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   // Debounce state registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_rep   <= '0;
         r_phase <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cand  <= w_cand_d;
         r_cnt   <= w_cnt_d;
         r_rep   <= w_rep_d;
         r_phase <= w_phase_d;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [KW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;
   logic          r_overflow;
   logic          w_pop, w_full, w_wr, w_drop;

   assign w_pop  = o_key_valid && i_key_ready;
   assign w_full = (r_count == CNT_FULL);
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands
   assign w_wr   = w_push && (!w_full || w_pop);
   assign w_drop = w_push && w_full && !w_pop;

   // Storage array; contents are masked on output while empty, so no reset
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_tot_code;
   end

   // Pointers, occupancy and sticky overflow (set beats clear)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop)              r_overflow <= 1'b1;
         else if (i_overflow_clr) r_overflow <= 1'b0;
      end
   end

   assign o_key_valid  = (r_count != '0);
   assign o_key_code   = o_key_valid ? r_mem[r_rd_ptr] : '0;
   assign o_fifo_count = r_count;
   assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: a 4x4 key-matrix model drives the rows from the
// column strobes; phases of held keys are applied from a table and the FIFO
// state is compared at each phase end, plus hand sequences for timing corners.
module tb_keypad_scan_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rows;
   logic [3:0] cols;
   logic       repeat_en;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       overflow_clr;

   logic [15:0] keys;
   int n_total = 0;
   int n_bad   = 0;
   int n_pops  = 0;

   localparam int FR = 64;  // cycles per frame with default parameters

   typedef struct {
      logic [15:0] keys;
      int          frames;
      bit          rep;
      bit          rdy;
      int          cnt;
      int          ovf;
      int          code;
      int          pops;
   } vec_t;

   vec_t tbl [25];

   keypad_scan_fifo dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rows         (rows),
      .o_cols         (cols),
      .i_repeat_en    (repeat_en),
      .o_key_valid    (key_valid),
      .o_key_code     (key_code),
      .i_key_ready    (key_ready),
      .o_fifo_count   (fifo_count),
      .o_overflow     (overflow),
      .i_overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key code r*4+c connects row r to column c
   always_comb begin
      rows = '0;
      for (int c = 0; c < 4; c++)
         if (cols[c])
            for (int r = 0; r < 4; r++)
               if (keys[r*4+c]) rows[r] = 1'b1;
   end

   // Consumer-side pop counter, sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n && key_valid && key_ready) n_pops++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      int p0;
      keys      = tbl[i].keys;
      repeat_en = tbl[i].rep;
      key_ready = tbl[i].rdy;
      p0        = n_pops;
      tick(FR * tbl[i].frames);
      chk($sformatf("vec%0d count", i), int'(fifo_count), tbl[i].cnt);
      chk($sformatf("vec%0d valid", i), int'(key_valid), (tbl[i].cnt != 0) ? 1 : 0);
      chk($sformatf("vec%0d code", i), int'(key_code), tbl[i].code);
      chk($sformatf("vec%0d overflow", i), int'(overflow), tbl[i].ovf);
      chk($sformatf("vec%0d pops", i), n_pops - p0, tbl[i].pops);
   endtask

   initial begin
      //          keys      frm rep rdy cnt ovf code pops
      tbl[0]  = '{16'h0200,  7, 1'b0, 1'b0, 1, 0,  9, 0};  // key 9 held on, no repeat
      tbl[1]  = '{16'h0000,  3, 1'b0, 1'b1, 0, 0,  0, 1};  // release, drain
      tbl[2]  = '{16'h0020,  2, 1'b0, 1'b0, 0, 0,  0, 0};  // bounce: 2 on
      tbl[3]  = '{16'h0000,  1, 1'b0, 1'b0, 0, 0,  0, 0};  // 1 off
      tbl[4]  = '{16'h0020,  2, 1'b0, 1'b0, 0, 0,  0, 0};  // 2 on
      tbl[5]  = '{16'h0000,  5, 1'b0, 1'b0, 0, 0,  0, 0};  // 5 off
      tbl[6]  = '{16'h0020,  3, 1'b0, 1'b0, 1, 0,  5, 0};  // 3 on -> accepted
      tbl[7]  = '{16'h0000,  3, 1'b0, 1'b1, 0, 0,  0, 1};
      tbl[8]  = '{16'h8000,  3, 1'b1, 1'b1, 1, 0, 15, 0};  // acceptance of 15
      tbl[9]  = '{16'h8000, 20, 1'b1, 1'b1, 1, 0, 15, 7};  // repeats +8..+20
      tbl[10] = '{16'h0000,  1, 1'b1, 1'b1, 0, 0,  0, 1};  // brief release
      tbl[11] = '{16'h8000,  3, 1'b1, 1'b1, 0, 0,  0, 0};  // re-press: no push
      tbl[12] = '{16'h0000,  3, 1'b0, 1'b0, 0, 0,  0, 0};
      tbl[13] = '{16'h0002,  3, 1'b0, 1'b0, 1, 0,  1, 0};  // fill: 1
      tbl[14] = '{16'h0000,  3, 1'b0, 1'b0, 1, 0,  1, 0};
      tbl[15] = '{16'h0004,  3, 1'b0, 1'b0, 2, 0,  1, 0};  // 2
      tbl[16] = '{16'h0000,  3, 1'b0, 1'b0, 2, 0,  1, 0};
      tbl[17] = '{16'h0008,  3, 1'b0, 1'b0, 3, 0,  1, 0};  // 3
      tbl[18] = '{16'h0000,  3, 1'b0, 1'b0, 3, 0,  1, 0};
      tbl[19] = '{16'h0010,  3, 1'b0, 1'b0, 4, 0,  1, 0};  // 4
      tbl[20] = '{16'h0000,  3, 1'b0, 1'b0, 4, 0,  1, 0};
      tbl[21] = '{16'h0040,  3, 1'b0, 1'b0, 4, 1,  1, 0};  // 6 dropped
      tbl[22] = '{16'h0000,  3, 1'b0, 1'b0, 4, 1,  1, 0};
      tbl[23] = '{16'h0021, 10, 1'b0, 1'b0, 0, 0,  0, 0};  // ghost 0+5
      tbl[24] = '{16'h0000,  1, 1'b0, 1'b0, 0, 0,  0, 0};

      rst_n = 1'b0; keys = '0; repeat_en = 1'b0; key_ready = 1'b0; overflow_clr = 1'b0;
      tick(3);
      rst_n = 1'b1;

      // Reset state and column rotation
      chk("rst cols", int'(cols), 1);
      chk("rst valid", int'(key_valid), 0);
      chk("rst count", int'(fifo_count), 0);
      chk("rst code", int'(key_code), 0);
      chk("rst overflow", int'(overflow), 0);
      tick(16); chk("cols step1", int'(cols), 2);
      tick(16); chk("cols step2", int'(cols), 4);
      tick(16); chk("cols step3", int'(cols), 8);
      tick(16); chk("cols wrap", int'(cols), 1);

      // Single press latency: valid rises right after the 3rd frame end
      keys = 16'h0200;
      tick(3*FR - 1);
      chk("press pre valid", int'(key_valid), 0);
      tick(1);
      chk("press valid", int'(key_valid), 1);
      chk("press code", int'(key_code), 9);
      chk("press count", int'(fifo_count), 1);

      for (int i = 0; i <= 12; i++) run_vec(i);
      for (int i = 13; i <= 22; i++) run_vec(i);

      // Overflow clear
      overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
      chk("ovf clr", int'(overflow), 0);
      chk("ovf clr count", int'(fifo_count), 4);
      tick(FR - 1);

      // Push and pop on the same edge while full: both succeed
      keys = 16'h0080;
      tick(3*FR - 1);
      key_ready = 1'b1; tick(1); key_ready = 1'b0;
      chk("full pushpop count", int'(fifo_count), 4);
      chk("full pushpop ovf", int'(overflow), 0);
      chk("full pushpop head", int'(key_code), 2);
      keys = '0; tick(3*FR);

      // Drop coinciding with a clear: the set wins
      keys = 16'h0100;
      tick(3*FR - 1);
      overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
      chk("set wins ovf", int'(overflow), 1);
      chk("set wins count", int'(fifo_count), 4);
      keys = '0; tick(3*FR);

      // Drain in order; 6 and 8 were lost
      begin
         logic [3:0] exp_q [4];
         exp_q[0] = 4'd2; exp_q[1] = 4'd3; exp_q[2] = 4'd4; exp_q[3] = 4'd7;
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d code", k), int'(key_code), int'(exp_q[k]));
            key_ready = 1'b1; tick(1); key_ready = 1'b0;
         end
      end
      chk("drain count", int'(fifo_count), 0);
      chk("drain valid", int'(key_valid), 0);
      chk("drain code", int'(key_code), 0);
      overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
      chk("final clr ovf", int'(overflow), 0);
      tick(FR - 5);

      run_vec(23);
      run_vec(24);

      // Reset mid-debounce discards the candidate
      keys = 16'h0080;
      tick(2*FR + 40);
      chk("midframe cols", int'(cols), 4);
      rst_n = 1'b0;
      #1;
      chk("async rst cols", int'(cols), 1);
      tick(2);
      rst_n = 1'b1;
      tick(FR);
      chk("post rst count", int'(fifo_count), 0);
      chk("post rst valid", int'(key_valid), 0);
      tick(2*FR);
      chk("post rst accept count", int'(fifo_count), 1);
      chk("post rst accept code", int'(key_code), 7);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised successor to the fixed 4x4 keyboard scanner used in the calculator.
- Drives one-hot column strobes and samples rows through a synchroniser.
- Debounces press and release in whole scan frames and supports optional auto-repeat.
- Queues key codes in a FIFO with a valid/ready pop handshake, consumed by the calculator logic on the same clock.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column strobes (2..8)
SCAN_DIV, 16, clock cycles each column is held; must be >= 4
DEBOUNCE, 3, consecutive identical frames required to accept a press or a release (>= 1)
FIFO_DEPTH, 4, key FIFO entries; power of 2, >= 2
REPEAT_DELAY, 8, frames after acceptance before the first auto-repeat
REPEAT_RATE, 2, frames between subsequent auto-repeats (>= 1)

Ports:
clk  in  1  system clock (LF oscillator domain)
rst  in  1  asynchronous, active-low reset
rows  in  ROWS  row sense lines, active-high when a key connects them to the driven column; asynchronous
cols  out  COLS  column strobes, one-hot active-high
repeat_en  in  1  1 = auto-repeat enabled while a key is held
key_valid  out  1  FIFO not empty
key_code  out  clog2(ROWS*COLS)  FIFO head; code = row*COLS + col
key_ready  in  1  consumer pop request
fifo_count  out  clog2(FIFO_DEPTH)+1  current number of entries
overflow  out  1  sticky flag: a push was dropped
overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, asynchronous):
  - cols=1 (column 0), column counter 0, slot counter 0.
  - FSM in IDLE, FIFO empty.
  - key_valid=0, key_code=0, fifo_count=0, overflow=0.
  - Reset mid-debounce or mid-hold discards all state; no push occurs.
- Synchroniser: rows passes through 2 flip-flops before use.
- Scan timing:
  - Slot counter runs 0..SCAN_DIV-1; column counter advances and wraps COLS-1 -> 0 when the slot counter wraps.
  - cols = one-hot(column counter).
  - Synchronised rows are sampled at slot cycle SCAN_DIV-1.
  - A frame is COLS*SCAN_DIV cycles and ends at the sample of column COLS-1.
- Frame classification: NONE (no bit set), SINGLE(k) (exactly one row/col hit), MULTI (two or more hits; ghosting is never decoded).
- FSM, evaluated once per frame end:
  - IDLE:
    - SINGLE(k) -> CAND with cand=k, cnt=1; if DEBOUNCE=1, push k and go to HELD instead.
    - Otherwise stay in IDLE.
  - CAND:
    - SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE, push cand, go to HELD, rep=0.
    - SINGLE(j != cand) -> restart CAND with cand=j, cnt=1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - SINGLE(cand) with repeat_en=1 -> rep+1. Push cand when rep reaches REPEAT_DELAY, then every further REPEAT_RATE frames.
    - SINGLE(cand) with repeat_en=0 -> rep held at 0.
    - MULTI -> stay in HELD, rep unchanged, no push.
    - NONE or SINGLE(j != cand) -> RELEASE, cnt=1.
  - RELEASE:
    - SINGLE(cand) -> HELD, rep=0, no push.
    - Otherwise cnt+1; when cnt reaches DEBOUNCE -> IDLE.
    - A new key is only accepted after returning to IDLE.
- FIFO:
  - A push is written on the frame-end cycle; key_valid rises the next cycle. Latency from the last accepting row sample to key_valid is 1 cycle.
  - Pop occurs when key_valid & key_ready; the head advances on the next cycle.
  - Push to a full FIFO with no pop: push is dropped, overflow=1.
  - Push and pop on the same cycle while full: both succeed, no overflow, count unchanged.
  - Push on the same cycle while empty: no pop (key_valid was 0).
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow_clr clears overflow. If a drop occurs on the same cycle, set wins.
- key_code is 0 whenever the FIFO is empty.

Test Plan:
- Reset release:
  - cols=0001, key_valid=0, fifo_count=0.
  - cols sequence 0001,0010,0100,1000,0001 at 16-cycle intervals.
  - Assert rst low mid-frame -> cols=0001 immediately.
- Single press:
  - Row 2 asserted whenever cols=0010 for 10 frames, key_ready=0, repeat_en=0.
  - Exactly one push, code 9, key_valid rising 1 cycle after the 3rd frame end; fifo_count=1.
- Bounce:
  - Code 5 present for 2 frames, absent 1, present 2, absent 5 -> no push.
  - Then present 3 frames -> one push, code 5.
- Auto-repeat, repeat_en=1, key_ready=1, code 15 held for 20 frames after acceptance:
  - Pushes at acceptance and at frames +8, +10, +12, +14, +16, +18, +20 (8 codes total).
  - Release, then re-press within 2 frames -> no extra push.
- Overflow, key_ready=0:
  - Press codes 1, 2, 3, 4, 6 in turn, with full release between presses -> fifo_count=4, overflow=1.
  - Pop order 1, 2, 3, 4; code 6 lost.
  - overflow_clr pulse -> overflow=0.
- Ghosting and reset:
  - Codes 0 and 5 pressed together from IDLE for 10 frames -> no push.
  - Code 7 pressed, rst pulsed after 2 frames, then 1 more frame of code 7 -> no push.
